// File: rtl/ysyx_22041071_ifu_axi_rd.sv
// ---------------------------------------------------------------------------
// ysyx_22041071_ifu_axi_rd
//
// Instruction-fetch AXI4 read master. Sits directly downstream of the PC
// stage: takes one fetch request, runs a single AR + R transaction on the AXI
// bus and hands the 32-bit instruction plus its PC to decode.
//
// Handshake semantics (all interfaces): a transfer happens on the rising edge
// where both valid and ready are high. A master holds valid and its payload
// stable until that edge; ready may be raised or dropped freely. cpu_ready is
// this block's ready for the PC stage (high only in IDLE).
//
// Ports
//   clk, reset         clock (rising edge) / asynchronous active-low reset
//   cpu_ar_valid       fetch request valid from the PC stage
//   cpu_addr/len/size  fetch address, burst length-1, beat size code
//   cpu_ready          request accepted this cycle when cpu_ar_valid is high
//   inst_valid         one-cycle pulse, inst/inst_pc valid
//   inst, inst_pc      fetched instruction and the address it came from
//   rd_err             one-cycle pulse with inst_valid on bad rresp / rlast
//   axi_ar*            AXI4 read-address channel (master side)
//   axi_r*             AXI4 read-data channel (master side)
//   dbg_state          current FSM state, for checkers and debug
//
// The instruction select uses rdata[63:32] / rdata[31:0], so DATA_W must be
// at least 64.
// ---------------------------------------------------------------------------
module ysyx_22041071_ifu_axi_rd #(
  parameter int          ADDR_W = 64,
  parameter int          DATA_W = 64,
  parameter int          LEN_W  = 8,
  parameter int          ID_W   = 4,
  parameter int unsigned IF_ID  = 0
) (
  input  logic              clk,
  input  logic              reset,

  // fetch request from the PC stage
  input  logic              cpu_ar_valid,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [LEN_W-1:0]  cpu_len,
  input  logic [1:0]        cpu_size,
  output logic              cpu_ready,

  // instruction to decode
  output logic              inst_valid,
  output logic [31:0]       inst,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              rd_err,

  // AXI4 read-address channel
  output logic              axi_arvalid,
  input  logic              axi_arready,
  output logic [ADDR_W-1:0] axi_araddr,
  output logic [ID_W-1:0]   axi_arid,
  output logic [LEN_W-1:0]  axi_arlen,
  output logic [2:0]        axi_arsize,
  output logic [1:0]        axi_arburst,

  // AXI4 read-data channel
  input  logic              axi_rvalid,
  output logic              axi_rready,
  input  logic [DATA_W-1:0] axi_rdata,
  input  logic [1:0]        axi_rresp,
  input  logic              axi_rlast,
  input  logic [ID_W-1:0]   axi_rid,

  // debug
  output logic [1:0]        dbg_state
);

  localparam logic [ID_W-1:0] IF_ID_L = ID_W'(IF_ID);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_AR   = 2'd1,
    S_R    = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t            state;
  logic              err_q;
  // One bit wider than arlen so an overlong burst (missing rlast) can never
  // wrap the count back onto a false "beat == arlen" match.
  logic [LEN_W:0]    beat_cnt;

  logic              beat_ok;
  logic              len_mismatch;
  logic              err_next;
  logic [LEN_W:0]    beat_cnt_next;
  logic [31:0]       inst_sel;

  // Constant AR fields: single ID, INCR bursts.
  assign axi_arid    = IF_ID_L;
  assign axi_arburst = 2'b01;

  assign cpu_ready   = (state == S_IDLE);
  assign dbg_state   = state;

  always_comb begin
    beat_ok       = 1'b0;
    len_mismatch  = 1'b0;
    err_next      = err_q;
    beat_cnt_next = beat_cnt;
    inst_sel      = axi_araddr[2] ? axi_rdata[63:32] : axi_rdata[31:0];

    // Beats tagged with a foreign rid are consumed (rready is high) but have
    // no effect on this transaction.
    beat_ok = (state == S_R) && axi_rvalid && axi_rready && (axi_rid == IF_ID_L);

    // rlast must arrive exactly on beat arlen: early rlast, or a beat at or
    // past arlen without rlast, are both protocol errors.
    if (axi_rlast)
      len_mismatch = (beat_cnt != {1'b0, axi_arlen});
    else
      len_mismatch = (beat_cnt >= {1'b0, axi_arlen});

    if (beat_ok) begin
      err_next = err_q | (axi_rresp != 2'b00) | len_mismatch;
      if (beat_cnt != {(LEN_W+1){1'b1}})
        beat_cnt_next = beat_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      axi_arvalid <= 1'b0;
      axi_rready  <= 1'b0;
      inst_valid  <= 1'b0;
      rd_err      <= 1'b0;
      inst        <= '0;
      inst_pc     <= '0;
      axi_araddr  <= '0;
      axi_arlen   <= '0;
      axi_arsize  <= '0;
      err_q       <= 1'b0;
      beat_cnt    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cpu_ar_valid) begin
            // The AR register doubles as the latched request for the whole
            // transaction (address select, inst_pc, expected burst length).
            axi_araddr  <= cpu_addr;
            axi_arlen   <= cpu_len;
            axi_arsize  <= {1'b0, cpu_size};
            axi_arvalid <= 1'b1;
            err_q       <= 1'b0;
            beat_cnt    <= '0;
            state       <= S_AR;
          end
        end

        S_AR: begin
          // arvalid is always high here, so arready alone completes it.
          if (axi_arready) begin
            axi_arvalid <= 1'b0;
            axi_rready  <= 1'b1;
            state       <= S_R;
          end
        end

        S_R: begin
          if (beat_ok) begin
            err_q    <= err_next;
            beat_cnt <= beat_cnt_next;
            if (beat_cnt == '0) begin
              inst    <= inst_sel;
              inst_pc <= axi_araddr;
            end
            if (axi_rlast) begin
              axi_rready <= 1'b0;
              inst_valid <= 1'b1;
              rd_err     <= err_next;
              state      <= S_DONE;
            end
          end
        end

        S_DONE: begin
          inst_valid <= 1'b0;
          rd_err     <= 1'b0;
          state      <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_22041071_ifu_axi_rd.sv
module tb_ysyx_22041071_ifu_axi_rd;

  // ------------------------------------------------------------------
  // Clock / reset
  // ------------------------------------------------------------------
  logic        clk;
  logic        reset;

  logic        cpu_ar_valid;
  logic [63:0] cpu_addr;
  logic [7:0]  cpu_len;
  logic [1:0]  cpu_size;
  logic        cpu_ready;
  logic        inst_valid;
  logic [31:0] inst;
  logic [63:0] inst_pc;
  logic        rd_err;
  logic        axi_arvalid;
  logic        axi_arready;
  logic [63:0] axi_araddr;
  logic [3:0]  axi_arid;
  logic [7:0]  axi_arlen;
  logic [2:0]  axi_arsize;
  logic [1:0]  axi_arburst;
  logic        axi_rvalid;
  logic        axi_rready;
  logic [63:0] axi_rdata;
  logic [1:0]  axi_rresp;
  logic        axi_rlast;
  logic [3:0]  axi_rid;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  ysyx_22041071_ifu_axi_rd dut (
    .clk          (clk),
    .reset        (reset),
    .cpu_ar_valid (cpu_ar_valid),
    .cpu_addr     (cpu_addr),
    .cpu_len      (cpu_len),
    .cpu_size     (cpu_size),
    .cpu_ready    (cpu_ready),
    .inst_valid   (inst_valid),
    .inst         (inst),
    .inst_pc      (inst_pc),
    .rd_err       (rd_err),
    .axi_arvalid  (axi_arvalid),
    .axi_arready  (axi_arready),
    .axi_araddr   (axi_araddr),
    .axi_arid     (axi_arid),
    .axi_arlen    (axi_arlen),
    .axi_arsize   (axi_arsize),
    .axi_arburst  (axi_arburst),
    .axi_rvalid   (axi_rvalid),
    .axi_rready   (axi_rready),
    .axi_rdata    (axi_rdata),
    .axi_rresp    (axi_rresp),
    .axi_rlast    (axi_rlast),
    .axi_rid      (axi_rid),
    .dbg_state    (dbg_state)
  );

  // ------------------------------------------------------------------
  // Checker
  // ------------------------------------------------------------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // ------------------------------------------------------------------
  // Scoreboard: expected {rd_err, inst_pc, inst} per completed fetch
  // ------------------------------------------------------------------
  logic [96:0] exp_q[$];
  logic [96:0] sb_e;

  always @(negedge clk) begin
    if (reset && inst_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_inst_valid", 64'(inst_valid), 64'd0);
      end else begin
        sb_e = exp_q.pop_front();
        check("sb_inst",    64'(inst),    64'(sb_e[31:0]));
        check("sb_inst_pc", inst_pc,      sb_e[95:32]);
        check("sb_rd_err",  64'(rd_err),  64'(sb_e[96]));
      end
    end
  end

  task automatic expect_fetch(input logic [31:0] e_inst, input logic [63:0] e_pc, input logic e_err);
    exp_q.push_back({e_err, e_pc, e_inst});
  endtask

  // ------------------------------------------------------------------
  // Driver tasks (all driving and sampling at negedge)
  // ------------------------------------------------------------------
  task automatic issue(input logic [63:0] addr, input logic [7:0] len, input logic [1:0] size);
    check("cpu_ready_idle", 64'(cpu_ready), 64'd1);
    cpu_ar_valid = 1'b1;
    cpu_addr     = addr;
    cpu_len      = len;
    cpu_size     = size;
    @(negedge clk);
    cpu_ar_valid = 1'b0;
    cpu_addr     = 64'h0000_0000_DEAD_0000;
    cpu_len      = 8'h5A;
    cpu_size     = 2'b00;
    check("arvalid_rise", 64'(axi_arvalid), 64'd1);
    check("araddr",       axi_araddr,       addr);
    check("arlen",        64'(axi_arlen),   64'(len));
    check("arsize",       64'(axi_arsize),  64'({1'b0, size}));
    check("arburst",      64'(axi_arburst), 64'd1);
    check("arid",         64'(axi_arid),    64'd0);
    check("cpu_ready_busy", 64'(cpu_ready), 64'd0);
  endtask

  // Holds arready low for 'stall' cycles (with a stray request on the CPU
  // side that must be ignored), then completes a single AR handshake.
  task automatic ar_phase(input int stall, input logic [63:0] addr);
    for (int i = 0; i < stall; i++) begin
      axi_arready  = 1'b0;
      cpu_ar_valid = 1'b1;
      cpu_addr     = 64'h0000_0000_1234_5678;
      @(negedge clk);
      check("ar_stall_arvalid", 64'(axi_arvalid), 64'd1);
      check("ar_stall_araddr",  axi_araddr,       addr);
      check("ar_stall_cpu_ready", 64'(cpu_ready), 64'd0);
    end
    cpu_ar_valid = 1'b0;
    axi_arready  = 1'b1;
    @(negedge clk);
    axi_arready  = 1'b0;
    check("ar_single_handshake", 64'(axi_arvalid), 64'd0);
    check("rready_in_r",         64'(axi_rready),  64'd1);
  endtask

  task automatic r_beat(input logic [63:0] data, input logic [1:0] resp, input logic last,
                        input logic [3:0] id);
    check("rready_beat", 64'(axi_rready), 64'd1);
    axi_rvalid = 1'b1;
    axi_rdata  = data;
    axi_rresp  = resp;
    axi_rlast  = last;
    axi_rid    = id;
    @(negedge clk);
    axi_rvalid = 1'b0;
    axi_rlast  = 1'b0;
    axi_rresp  = 2'b00;
    axi_rid    = 4'd0;
  endtask

  // Called on the negedge right after the rlast beat (the DONE cycle).
  task automatic done_phase();
    check("done_inst_valid", 64'(inst_valid), 64'd1);
    check("done_cpu_ready",  64'(cpu_ready),  64'd0);
    check("done_state",      64'(dbg_state),  64'd3);
    check("done_rready",     64'(axi_rready), 64'd0);
    @(negedge clk);
    check("idle_inst_valid", 64'(inst_valid), 64'd0);
    check("idle_rd_err",     64'(rd_err),     64'd0);
    check("idle_cpu_ready",  64'(cpu_ready),  64'd1);
  endtask

  // ------------------------------------------------------------------
  // Directed tests
  // ------------------------------------------------------------------
  initial begin
    reset        = 1'b0;
    cpu_ar_valid = 1'b0;
    cpu_addr     = '0;
    cpu_len      = '0;
    cpu_size     = '0;
    axi_arready  = 1'b0;
    axi_rvalid   = 1'b0;
    axi_rdata    = '0;
    axi_rresp    = '0;
    axi_rlast    = 1'b0;
    axi_rid      = '0;
    repeat (2) @(negedge clk);

    // reset state
    check("rst_arvalid",    64'(axi_arvalid), 64'd0);
    check("rst_rready",     64'(axi_rready),  64'd0);
    check("rst_inst_valid", 64'(inst_valid),  64'd0);
    check("rst_rd_err",     64'(rd_err),      64'd0);
    check("rst_inst",       64'(inst),        64'd0);
    check("rst_inst_pc",    inst_pc,          64'd0);
    check("rst_araddr",     axi_araddr,       64'd0);
    check("rst_arlen",      64'(axi_arlen),   64'd0);
    check("rst_arsize",     64'(axi_arsize),  64'd0);
    check("rst_cpu_ready",  64'(cpu_ready),   64'd1);
    check("rst_state",      64'(dbg_state),   64'd0);
    reset = 1'b1;
    @(negedge clk);

    // 1: lower half, zero-wait, latency cycle 0 -> 3
    expect_fetch(32'h0000_0093, 64'h8000_0000, 1'b0);
    issue(64'h8000_0000, 8'd0, 2'b10);
    ar_phase(0, 64'h8000_0000);
    r_beat(64'h0000_0013_0000_0093, 2'b00, 1'b1, 4'd0);
    done_phase();

    // 2: upper half selected by addr[2]
    expect_fetch(32'h0000_0013, 64'h8000_0004, 1'b0);
    issue(64'h8000_0004, 8'd0, 2'b10);
    ar_phase(0, 64'h8000_0004);
    r_beat(64'h0000_0013_0000_0093, 2'b00, 1'b1, 4'd0);
    done_phase();

    // 3: arready held low 5 cycles
    expect_fetch(32'h0010_0513, 64'h8000_0100, 1'b0);
    issue(64'h8000_0100, 8'd0, 2'b11);
    ar_phase(5, 64'h8000_0100);
    r_beat(64'hFFFF_FFFF_0010_0513, 2'b00, 1'b1, 4'd0);
    done_phase();

    // two-beat burst, proper rlast: inst from beat 0 only
    expect_fetch(32'h3333_4444, 64'h8000_0008, 1'b0);
    issue(64'h8000_0008, 8'd1, 2'b11);
    ar_phase(0, 64'h8000_0008);
    r_beat(64'h1111_2222_3333_4444, 2'b00, 1'b0, 4'd0);
    check("mid_burst_inst_valid", 64'(inst_valid), 64'd0);
    r_beat(64'h5555_6666_7777_8888, 2'b00, 1'b1, 4'd0);
    done_phase();

    // 4a: rresp SLVERR
    expect_fetch(32'h0000_0093, 64'h8000_0010, 1'b1);
    issue(64'h8000_0010, 8'd0, 2'b10);
    ar_phase(0, 64'h8000_0010);
    r_beat(64'h0000_0013_0000_0093, 2'b10, 1'b1, 4'd0);
    done_phase();

    // 4b: early rlast with arlen=1
    expect_fetch(32'hCAFE_0001, 64'h8000_0014, 1'b1);
    issue(64'h8000_0014, 8'd1, 2'b11);
    ar_phase(0, 64'h8000_0014);
    r_beat(64'hCAFE_0001_BEEF_0002, 2'b00, 1'b1, 4'd0);
    done_phase();

    // 4c: missing rlast on beat arlen=0, stays in R until rlast
    expect_fetch(32'hAAAA_0001, 64'h8000_000C, 1'b1);
    issue(64'h8000_000C, 8'd0, 2'b10);
    ar_phase(0, 64'h8000_000C);
    r_beat(64'hAAAA_0001_BBBB_0002, 2'b00, 1'b0, 4'd0);
    check("no_rlast_state_r", 64'(dbg_state), 64'd2);
    r_beat(64'h1234_5678_9ABC_DEF0, 2'b00, 1'b1, 4'd0);
    done_phase();

    // 5: foreign rid beat dropped
    expect_fetch(32'h0010_0073, 64'h8000_0020, 1'b0);
    issue(64'h8000_0020, 8'd0, 2'b10);
    ar_phase(0, 64'h8000_0020);
    r_beat(64'hDEAD_BEEF_DEAD_BEEF, 2'b00, 1'b1, 4'd3);
    check("rid_drop_state_r", 64'(dbg_state), 64'd2);
    r_beat(64'h0000_0000_0010_0073, 2'b00, 1'b1, 4'd0);
    done_phase();

    // 6: reset during R abandons the transaction
    issue(64'h8000_0040, 8'd0, 2'b10);
    ar_phase(0, 64'h8000_0040);
    reset = 1'b0;
    #1;
    check("arst_rready",     64'(axi_rready),  64'd0);
    check("arst_arvalid",    64'(axi_arvalid), 64'd0);
    check("arst_inst",       64'(inst),        64'd0);
    check("arst_inst_pc",    inst_pc,          64'd0);
    check("arst_araddr",     axi_araddr,       64'd0);
    check("arst_inst_valid", 64'(inst_valid),  64'd0);
    check("arst_state",      64'(dbg_state),   64'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("post_rst_rready", 64'(axi_rready), 64'd0);
    expect_fetch(32'h0000_0117, 64'h8000_0204, 1'b0);
    issue(64'h8000_0204, 8'd0, 2'b10);
    ar_phase(0, 64'h8000_0204);
    r_beat(64'h0000_0117_0000_0297, 2'b00, 1'b1, 4'd0);
    done_phase();

    repeat (2) @(negedge clk);
    check("sb_queue_drained", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
